decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Parametrised, pipelined RISC-V decode stage that sits between fetch and execute.
- Accepts one instruction word plus its PC over a valid/ready handshake and emits one registered decoded bundle over a second valid/ready handshake.
- A 2-entry skid buffer provides full throughput under backpressure.
- Each instruction is decoded exactly once per handshake; there is no dedup-by-comparison of repeated words.
- Supports RV32I/RV64I plus M, selected by XLEN; flags illegal encodings.

Parameters:
- XLEN, 64, datapath width (32 or 64). At 32, all OP-32/OP-IMM-32 opcodes and ld/lwu/sd are illegal, and shamt[5]=1 is illegal.
- M_EXT, 1, enables mul/div/rem decoding. At 0, funct7=0000001 in OP/OP-32 is illegal.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction word valid
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  XLEN  PC of the instruction
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts the bundle
- out_pc  out  XLEN  PC passthrough
- out_rd, out_rs1, out_rs2  out  5 each  register indices
- out_imm  out  XLEN  sign-extended immediate; zero-extended shamt for shift-immediates
- out_alu_op  out  4  alu_op_t
- out_reg_write  out  1  writes rd (forced 0 when rd==0 or illegal)
- out_mem_read, out_mem_write  out  1 each
- out_mem_size  out  2  0=B 1=H 2=W 3=D
- out_mem_unsigned  out  1
- out_branch, out_jump  out  1 each
- out_word_op  out  1  32-bit W-variant op
- out_illegal  out  1  unrecognised or disallowed encoding

Behaviour:
- Reset (async, reset=0): out_valid=0, in_ready=1, skid empty, all bundle outputs 0. Release is synchronous to clk. A bundle in flight when reset asserts is discarded.
- Decode is combinational on in_instr. The result is registered when in_valid && in_ready. Latency is 1 cycle from accept to out_valid.
- Storage: main register M and skid register S.
  - in_ready = !S.valid.
  - Output shows M.
  - On out_ready && out_valid: M <= S if S.valid, else M <= incoming (if accepted), else M.valid <= 0.
  - On accept while M.valid && !out_ready: write S.
  - Simultaneous accept and drain with S empty: M <= incoming, no bubble.
- Order is strictly FIFO. Sustained throughput is 1 per cycle when out_ready=1.
- Immediate formats: I, S, B, U, J, each sign-extended from bit 31 to XLEN.
  - B and J immediates have LSB 0.
  - U: {instr[31:12],12'b0} sign-extended.
- alu_op_t encoding: 0 NONE, 1 ADD, 2 SUB, 3 MUL, 4 DIV, 5 XOR, 6 AND, 7 OR, 8 SLL, 9 SRL, 10 SRA, 11 SLT, 12 SLTU, 13 REM, 14 PASSB (lui).
  - Loads, stores and auipc use ADD.
  - Branches use SUB (beq/bne/blt/bge) or SLTU (bltu/bgeu); the execute stage reads funct3 via out_branch plus the kept instruction bits.
  - jal/jalr use ADD (target) with reg_write=1.
- mul/mulh/mulhsu/mulhu all map to MUL; div/divu map to DIV; rem/remu map to REM. Signedness is carried in out_mem_unsigned, which is reused as the "unsigned" flag for M ops.
- Illegal encodings:
  - Unknown opcode; funct3/funct7 combinations outside the ISA; opcode bits [1:0] != 11; 0x00000000; 0xFFFFFFFF.
  - For an illegal instruction, all side-effect flags (reg_write, mem_*, branch, jump) are 0, but the bundle still flows with out_illegal=1.

Optional Feature:
- DECODE_TRACE_EN
  - Defined: on each output handshake, a simulation-only $display prints PC, mnemonic and operands, with pseudo-instruction aliases (nop, mv, li, j, ret, beqz, not, neg, sext.w).
  - Undefined: no trace code is compiled; the RTL is identical otherwise.

Decomposition:
- Package decode_pkg holds: alu_op_t enum, opcode localparams (OP, OP_IMM, OP_32, OP_IMM_32, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC), mem_size constants, and the packed decoded_t struct.
- One sub-module, decode_comb: pure combinational instr -> decoded_t, instantiated once ahead of the skid logic. The same module is reusable by the trace printer.

Test Plan:
- XLEN=64, in 0x00510093 (addi x1,x2,5) -> next cycle out_valid=1, rd=1, rs1=2, imm=5, alu_op=ADD, reg_write=1, illegal=0.
- XLEN=32, in 0x002081BB (addw x3,x1,x2) -> illegal=1, reg_write=0. With XLEN=64 -> alu_op=ADD, word_op=1, reg_write=1.
- In 0xFE20AE23 (sw x2,-4(x1)) -> rs1=1, rs2=2, imm=all-ones...FC, mem_write=1, mem_size=2, reg_write=0.
- Backpressure: send A, B, C back-to-back with out_ready=0 for 3 cycles.
  - in_ready falls after B is accepted; C is held.
  - When out_ready=1, outputs appear as A, B, C on consecutive cycles with no loss or duplication.
- Reset asserted mid-stream with M and S full -> out_valid=0 and in_ready=1 immediately (asynchronously). After release, the first new instruction appears with 1-cycle latency.
- Illegal and edge encodings:
  - 0x00000000 -> illegal=1.
  - 0x00000073 -> illegal=1.
  - addi x0,x0,0 -> reg_write=0, illegal=0.
  - M_EXT=0 with mul -> illegal=1.

Source files
------------

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared types, opcodes and helpers for the RISC-V decode stage
package decode_pkg;

    typedef enum logic [3:0] {
        ALU_NONE  = 4'd0,
        ALU_ADD   = 4'd1,
        ALU_SUB   = 4'd2,
        ALU_MUL   = 4'd3,
        ALU_DIV   = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_AND   = 4'd6,
        ALU_OR    = 4'd7,
        ALU_SLL   = 4'd8,
        ALU_SRL   = 4'd9,
        ALU_SRA   = 4'd10,
        ALU_SLT   = 4'd11,
        ALU_SLTU  = 4'd12,
        ALU_REM   = 4'd13,
        ALU_PASSB = 4'd14
    } alu_op_t;

    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_32     = 7'b0111011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;

    localparam logic [1:0] MEM_B = 2'd0;
    localparam logic [1:0] MEM_H = 2'd1;
    localparam logic [1:0] MEM_W = 2'd2;
    localparam logic [1:0] MEM_D = 2'd3;

    // Immediate is always carried at 64 bits; narrower datapaths keep the low XLEN bits.
    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] imm;
        alu_op_t     alu_op;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [1:0]  mem_size;
        logic        mem_unsigned;
        logic        branch;
        logic        jump;
        logic        word_op;
        logic        illegal;
    } decoded_t;

    function automatic alu_op_t base_alu(input logic [2:0] f3);
        case (f3)
            3'd0:    return ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_comb.sv
// rtl/decode_comb.sv - purely combinational RV32I/RV64I+M instruction word to decoded_t
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int M_EXT = 1
) (
    input  logic [31:0] instr,
    output decoded_t    dec
);

    localparam bit RV64 = (XLEN == 64);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    logic        w_op, w_ok, sh_ok;
    logic        legal, use_rd, use_rs1, use_rs2;

    assign opc    = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm_i  = {{52{instr[31]}}, instr[31:20]};
    assign imm_s  = {{52{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {{32{instr[31]}}, instr[31:12], 12'd0};
    assign imm_j  = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_sh = {58'd0, instr[25:20]};

    // W-variants only exist on RV64, and shamt[5] only on full-width RV64 shifts.
    assign w_op  = (opc == OP_32) || (opc == OP_IMM_32);
    assign w_ok  = !w_op || RV64;
    assign sh_ok = !instr[25] || (RV64 && !w_op);

    always_comb begin
        dec     = '0;
        legal   = 1'b0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opc)
            LUI: begin
                legal = 1'b1; use_rd = 1'b1;
                dec.alu_op = ALU_PASSB; dec.imm = imm_u;
            end
            AUIPC: begin
                legal = 1'b1; use_rd = 1'b1;
                dec.alu_op = ALU_ADD; dec.imm = imm_u;
            end
            JAL: begin
                legal = 1'b1; use_rd = 1'b1;
                dec.alu_op = ALU_ADD; dec.imm = imm_j; dec.jump = 1'b1;
            end
            JALR: begin
                legal = (f3 == 3'd0); use_rd = 1'b1; use_rs1 = 1'b1;
                dec.alu_op = ALU_ADD; dec.imm = imm_i; dec.jump = 1'b1;
            end
            BRANCH: begin
                legal = (f3 != 3'd2) && (f3 != 3'd3); use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec.alu_op = (f3[2:1] == 2'b11) ? ALU_SLTU : ALU_SUB;
                dec.imm = imm_b; dec.branch = 1'b1;
            end
            LOAD: begin
                legal = (f3 != 3'd7) && (RV64 || ((f3 != 3'd3) && (f3 != 3'd6)));
                use_rd = 1'b1; use_rs1 = 1'b1;
                dec.alu_op = ALU_ADD; dec.imm = imm_i; dec.mem_read = 1'b1;
                dec.mem_size = f3[1:0]; dec.mem_unsigned = f3[2];
            end
            STORE: begin
                legal = !f3[2] && (RV64 || (f3 != 3'd3)); use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec.alu_op = ALU_ADD; dec.imm = imm_s; dec.mem_write = 1'b1;
                dec.mem_size = f3[1:0];
            end
            OP_IMM, OP_IMM_32: begin
                use_rd = 1'b1; use_rs1 = 1'b1;
                dec.word_op = w_op; dec.imm = imm_i; dec.alu_op = base_alu(f3);
                case (f3)
                    3'd0: legal = w_ok;
                    3'd1: begin
                        legal = w_ok && sh_ok && (instr[31:26] == 6'b000000);
                        dec.imm = imm_sh;
                    end
                    3'd5: begin
                        legal = w_ok && sh_ok &&
                                ((instr[31:26] == 6'b000000) || (instr[31:26] == 6'b010000));
                        dec.imm = imm_sh;
                        if (instr[30]) dec.alu_op = ALU_SRA;
                    end
                    default: legal = !w_op;
                endcase
            end
            OP, OP_32: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec.word_op = w_op;
                if (f7 == 7'b0000000) begin
                    dec.alu_op = base_alu(f3);
                    legal = w_ok && (!w_op || (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd5));
                end else if (f7 == 7'b0100000) begin
                    dec.alu_op = (f3 == 3'd0) ? ALU_SUB : ALU_SRA;
                    legal = w_ok && ((f3 == 3'd0) || (f3 == 3'd5));
                end else if ((f7 == 7'b0000001) && (M_EXT != 0)) begin
                    // mulhu/divu/remu are the unsigned forms; mulhsu is resolved from funct3 downstream.
                    dec.alu_op = f3[2] ? (f3[1] ? ALU_REM : ALU_DIV) : ALU_MUL;
                    dec.mem_unsigned = f3[0] && (f3 != 3'd1);
                    legal = w_ok && (!w_op || (f3 == 3'd0) || f3[2]);
                end
            end
            default: legal = 1'b0;
        endcase
        dec.rd        = use_rd  ? instr[11:7]  : 5'd0;
        dec.rs1       = use_rs1 ? instr[19:15] : 5'd0;
        dec.rs2       = use_rs2 ? instr[24:20] : 5'd0;
        dec.reg_write = use_rd && (instr[11:7] != 5'd0);
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered decode stage with 2-entry skid; DECODE_TRACE_EN adds a sim trace
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int M_EXT = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic [3:0]      out_alu_op,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic [1:0]      out_mem_size,
    output logic            out_mem_unsigned,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_word_op,
    output logic            out_illegal
);

    decoded_t        in_dec, m_dec, s_dec;
    logic [XLEN-1:0] m_pc, s_pc;
    logic            m_valid, s_valid;
    logic            accept, drain;

    decode_comb #(.XLEN(XLEN), .M_EXT(M_EXT)) u_decode_comb (
        .instr (in_instr),
        .dec   (in_dec)
    );

    assign in_ready = !s_valid;
    assign accept   = in_valid && in_ready;
    assign drain    = m_valid && out_ready;

    // M is the visible slot; S only fills when M is stalled, so FIFO order is M then S.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_dec   <= '0;
            s_dec   <= '0;
            m_pc    <= '0;
            s_pc    <= '0;
        end else if (drain) begin
            if (s_valid) begin
                m_dec   <= s_dec;
                m_pc    <= s_pc;
                s_valid <= 1'b0;
            end else if (accept) begin
                m_dec <= in_dec;
                m_pc  <= in_pc;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (accept) begin
            if (!m_valid) begin
                m_valid <= 1'b1;
                m_dec   <= in_dec;
                m_pc    <= in_pc;
            end else begin
                s_valid <= 1'b1;
                s_dec   <= in_dec;
                s_pc    <= in_pc;
            end
        end
    end

    assign out_valid        = m_valid;
    assign out_pc           = m_pc;
    assign out_rd           = m_dec.rd;
    assign out_rs1          = m_dec.rs1;
    assign out_rs2          = m_dec.rs2;
    assign out_imm          = m_dec.imm[XLEN-1:0];
    assign out_alu_op       = m_dec.alu_op;
    assign out_reg_write    = m_dec.reg_write;
    assign out_mem_read     = m_dec.mem_read;
    assign out_mem_write    = m_dec.mem_write;
    assign out_mem_size     = m_dec.mem_size;
    assign out_mem_unsigned = m_dec.mem_unsigned;
    assign out_branch       = m_dec.branch;
    assign out_jump         = m_dec.jump;
    assign out_word_op      = m_dec.word_op;
    assign out_illegal      = m_dec.illegal;

`ifdef DECODE_TRACE_EN
    logic [31:0] m_instr, s_instr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_instr <= '0;
            s_instr <= '0;
        end else begin
            if (drain) m_instr <= s_valid ? s_instr : in_instr;
            else if (accept && !m_valid) m_instr <= in_instr;
            if (accept && m_valid && !drain) s_instr <= in_instr;
        end
    end

    function automatic string mnemonic(input logic [31:0] i, input decoded_t d);
        if (d.illegal) return "illegal";
        if (i == 32'h00000013) return "nop";
        if (i == 32'h00008067) return "ret";
        if (i[6:0] == OP_IMM && i[14:12] == 3'd0)
            return (i[31:20] == 12'd0) ? "mv" : ((i[19:15] == 5'd0) ? "li" : "addi");
        if (i[6:0] == OP_IMM && i[14:12] == 3'd4 && i[31:20] == 12'hfff) return "not";
        if (i[6:0] == OP && i[31:25] == 7'b0100000 && i[14:12] == 3'd0 && i[19:15] == 5'd0)
            return "neg";
        if (i[6:0] == OP_IMM_32 && i[14:12] == 3'd0 && i[31:20] == 12'd0) return "sext.w";
        if (i[6:0] == JAL && i[11:7] == 5'd0) return "j";
        if (i[6:0] == BRANCH && i[14:12] == 3'd0 && i[24:20] == 5'd0) return "beqz";
        return $sformatf("%s%s", d.alu_op.name(), d.word_op ? "w" : "");
    endfunction

    always @(posedge clk) begin
        if (reset && out_valid && out_ready)
            $display("%h: %s rd=x%0d rs1=x%0d rs2=x%0d imm=%0d", m_pc,
                     mnemonic(m_instr, m_dec), m_dec.rd, m_dec.rs1, m_dec.rs2,
                     $signed(out_imm));
    end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed vector bench for decode_stage at RV64, RV32 and RV64 without M
module tb_decode_stage;

    localparam logic [3:0] A_NONE = 4'd0, A_ADD = 4'd1, A_SUB = 4'd2, A_MUL = 4'd3, A_DIV = 4'd4;
    localparam logic [3:0] A_SLL = 4'd8, A_SRA = 4'd10, A_PASSB = 4'd14;
    localparam logic [92:0] ILL = 93'd1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_instr = '0;
    logic [63:0] in_pc = '0;

    always #5 clk = ~clk;

    logic        in_ready, out_valid, out_reg_write, out_mem_read, out_mem_write;
    logic        out_mem_unsigned, out_branch, out_jump, out_word_op, out_illegal;
    logic [63:0] out_pc, out_imm;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [3:0]  out_alu_op;
    logic [1:0]  out_mem_size;

    logic        w_in_ready, w_out_valid, w_rw, w_mr, w_mw, w_uns, w_br, w_jmp, w_wd, w_ill;
    logic [31:0] w_pc, w_imm;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [3:0]  w_alu;
    logic [1:0]  w_sz;

    logic        n_in_ready, n_out_valid, n_rw, n_mr, n_mw, n_uns, n_br, n_jmp, n_wd, n_ill;
    logic [63:0] n_pc, n_imm;
    logic [4:0]  n_rd, n_rs1, n_rs2;
    logic [3:0]  n_alu;
    logic [1:0]  n_sz;

    decode_stage #(.XLEN(64), .M_EXT(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .out_alu_op(out_alu_op), .out_reg_write(out_reg_write),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_mem_size(out_mem_size), .out_mem_unsigned(out_mem_unsigned),
        .out_branch(out_branch), .out_jump(out_jump), .out_word_op(out_word_op),
        .out_illegal(out_illegal)
    );

    decode_stage #(.XLEN(32), .M_EXT(1)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(w_out_valid), .out_ready(out_ready),
        .out_pc(w_pc), .out_rd(w_rd), .out_rs1(w_rs1), .out_rs2(w_rs2),
        .out_imm(w_imm), .out_alu_op(w_alu), .out_reg_write(w_rw),
        .out_mem_read(w_mr), .out_mem_write(w_mw), .out_mem_size(w_sz),
        .out_mem_unsigned(w_uns), .out_branch(w_br), .out_jump(w_jmp),
        .out_word_op(w_wd), .out_illegal(w_ill)
    );

    decode_stage #(.XLEN(64), .M_EXT(0)) dut_nom (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(n_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(n_out_valid), .out_ready(out_ready),
        .out_pc(n_pc), .out_rd(n_rd), .out_rs1(n_rs1), .out_rs2(n_rs2),
        .out_imm(n_imm), .out_alu_op(n_alu), .out_reg_write(n_rw),
        .out_mem_read(n_mr), .out_mem_write(n_mw), .out_mem_size(n_sz),
        .out_mem_unsigned(n_uns), .out_branch(n_br), .out_jump(n_jmp),
        .out_word_op(n_wd), .out_illegal(n_ill)
    );

    logic [92:0] act64;
    assign act64 = {out_rd, out_rs1, out_rs2, out_imm, out_alu_op, out_reg_write, out_mem_read,
                    out_mem_write, out_mem_size, out_mem_unsigned, out_branch, out_jump,
                    out_word_op, out_illegal};

    typedef struct packed {
        logic [31:0] instr;
        logic [92:0] exp;
        logic        ill32;
        logic        illn;
    } vec_t;

    vec_t vecs [18];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [92:0] mk(input logic [4:0] rd, rs1, rs2, input logic [63:0] imm,
                                       input logic [3:0] alu, input logic rw, mr, mw,
                                       input logic [1:0] sz, input logic uns, br, jmp, wd);
        return {rd, rs1, rs2, imm, alu, rw, mr, mw, sz, uns, br, jmp, wd, 1'b0};
    endfunction

    function automatic logic [31:0] addi_x(input logic [4:0] n);
        return {7'd0, n, 5'd0, 3'd0, n, 7'b0010011};
    endfunction

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{32'h00510093, mk(5'd1, 5'd2, 5'd0, 64'd5, A_ADD, 1, 0, 0, 2'd0, 0, 0, 0, 0), 1'b0, 1'b0};
        vecs[1]  = '{32'h002081BB, mk(5'd3, 5'd1, 5'd2, 64'd0, A_ADD, 1, 0, 0, 2'd0, 0, 0, 0, 1), 1'b1, 1'b0};
        vecs[2]  = '{32'hFE20AE23, mk(5'd0, 5'd1, 5'd2, 64'hFFFFFFFF_FFFFFFFC, A_ADD, 0, 0, 1, 2'd2, 0, 0, 0, 0), 1'b0, 1'b0};
        vecs[3]  = '{32'h00000000, ILL, 1'b1, 1'b1};
        vecs[4]  = '{32'h00000073, ILL, 1'b1, 1'b1};
        vecs[5]  = '{32'hFFFFFFFF, ILL, 1'b1, 1'b1};
        vecs[6]  = '{32'h00000013, mk(5'd0, 5'd0, 5'd0, 64'd0, A_ADD, 0, 0, 0, 2'd0, 0, 0, 0, 0), 1'b0, 1'b0};
        vecs[7]  = '{32'h027302B3, mk(5'd5, 5'd6, 5'd7, 64'd0, A_MUL, 1, 0, 0, 2'd0, 0, 0, 0, 0), 1'b0, 1'b1};
        vecs[8]  = '{32'h027352B3, mk(5'd5, 5'd6, 5'd7, 64'd0, A_DIV, 1, 0, 0, 2'd0, 1, 0, 0, 0), 1'b0, 1'b1};
        vecs[9]  = '{32'h80000537, mk(5'd10, 5'd0, 5'd0, 64'hFFFFFFFF_80000000, A_PASSB, 1, 0, 0, 2'd0, 0, 0, 0, 0), 1'b0, 1'b0};
        vecs[10] = '{32'h00208463, mk(5'd0, 5'd1, 5'd2, 64'd8, A_SUB, 0, 0, 0, 2'd0, 0, 1, 0, 0), 1'b0, 1'b0};
        vecs[11] = '{32'hFFDFF0EF, mk(5'd1, 5'd0, 5'd0, 64'hFFFFFFFF_FFFFFFFC, A_ADD, 1, 0, 0, 2'd0, 0, 0, 1, 0), 1'b0, 1'b0};
        vecs[12] = '{32'h00833283, mk(5'd5, 5'd6, 5'd0, 64'd8, A_ADD, 1, 1, 0, 2'd3, 0, 0, 0, 0), 1'b1, 1'b0};
        vecs[13] = '{32'h00034283, mk(5'd5, 5'd6, 5'd0, 64'd0, A_ADD, 1, 1, 0, 2'd0, 1, 0, 0, 0), 1'b0, 1'b0};
        vecs[14] = '{32'h02109093, mk(5'd1, 5'd1, 5'd0, 64'd33, A_SLL, 1, 0, 0, 2'd0, 0, 0, 0, 0), 1'b1, 1'b0};
        vecs[15] = '{32'h4030D093, mk(5'd1, 5'd1, 5'd0, 64'd3, A_SRA, 1, 0, 0, 2'd0, 0, 0, 0, 0), 1'b0, 1'b0};
        vecs[16] = '{32'h402090B3, ILL, 1'b1, 1'b1};
        vecs[17] = '{32'h00510090, ILL, 1'b1, 1'b1};

        #2;
        check("reset_state", {out_valid, in_ready, out_pc, act64}, {1'b0, 1'b1, 64'd0, 93'd0});
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Streamed back to back with out_ready=1: each vector appears one cycle after accept.
        for (int i = 0; i < 18; i++) begin
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            in_pc    = 64'h1000 + 64'(4 * i);
            @(posedge clk); #1;
            check($sformatf("vec%0d_rv64", i), {out_valid, in_ready, out_pc, act64},
                  {1'b1, 1'b1, 64'h1000 + 64'(4 * i), vecs[i].exp});
            check($sformatf("vec%0d_rv32_illegal", i), {w_out_valid, w_ill}, {1'b1, vecs[i].ill32});
            check($sformatf("vec%0d_nom_illegal", i), {n_out_valid, n_ill}, {1'b1, vecs[i].illn});
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("stream_drained", out_valid, 1'b0);

        // Backpressure: A, B accepted into M/S, C held until a slot frees.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = addi_x(5'd1);
        @(posedge clk); #1;
        check("bp_a_accepted", {out_valid, in_ready, out_rd}, {1'b1, 1'b1, 5'd1});
        in_instr = addi_x(5'd2);
        @(posedge clk); #1;
        check("bp_b_fills_skid", {out_valid, in_ready, out_rd}, {1'b1, 1'b0, 5'd1});
        in_instr = addi_x(5'd3);
        @(posedge clk); #1;
        check("bp_c_held", {out_valid, in_ready, out_rd}, {1'b1, 1'b0, 5'd1});
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_out_b", {out_valid, in_ready, out_rd}, {1'b1, 1'b1, 5'd2});
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_out_c", {out_valid, out_rd}, {1'b1, 5'd3});
        @(posedge clk); #1;
        check("bp_no_duplicate", out_valid, 1'b0);

        // Asynchronous reset with both slots full discards everything immediately.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = addi_x(5'd4);
        @(posedge clk); #1;
        in_instr = addi_x(5'd5);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rst_full_before", {out_valid, in_ready, out_rd}, {1'b1, 1'b0, 5'd4});
        #2 reset = 1'b0;
        #1;
        check("rst_async_clear", {out_valid, in_ready, act64}, {1'b0, 1'b1, 93'd0});
        @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("rst_nothing_left", out_valid, 1'b0);
        in_valid = 1'b1;
        in_instr = addi_x(5'd6);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rst_first_new", {out_valid, out_rd, out_imm}, {1'b1, 5'd6, 64'd6});
        @(posedge clk); #1;
        check("rst_single_out", out_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
